// File: rtl/bc_pulse_gen.sv
// bc_pulse_gen: pulse-train transmitter for the 2-bit pulse counter.
//
// A start request in IDLE loads a count N. The block then drives exactly N
// single-cycle pulses on x, separated by GAP idle cycles. After the last
// pulse it strobes done for one cycle. Pulses launch on the rising edge, so
// a counter that samples on the falling edge sees x stable for half a cycle.
//
// Optional feature: define BC_PG_ABORT_EN to add the abort input. It forces
// an early finish from PULSE or GAP.
//
// Parameters:
//   WIDTH      width of count / remaining (max pulses = 2^WIDTH-1)
//   GAP        idle cycles between consecutive pulses, 0..15
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous active-low reset
//   start      run request, sampled only in IDLE
//   count      number of pulses, captured on the accepting edge
//   abort      (BC_PG_ABORT_EN only) early termination from PULSE/GAP
//   x          pulse output, decoded from registered state
//   busy       high in PULSE and GAP
//   done       one-cycle completion strobe
//   remaining  pulses still to send; holds its value in IDLE/DONE
module bc_pulse_gen #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] count,
`ifdef BC_PG_ABORT_EN
  input  logic             abort,
`endif
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Reload value for the gap counter: the counter reaches 0 in the last gap cycle.
  localparam logic [3:0] GAP_INIT = 4'((GAP == 0) ? 0 : GAP - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] rem_dec;
  logic [3:0]       gap_cnt, gap_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_n;
      remaining <= rem_n;
      gap_cnt   <= gap_n;
    end
  end

  assign rem_dec = remaining - WIDTH'(1);

  always_comb begin
    state_n = state;
    rem_n   = remaining;
    gap_n   = gap_cnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            rem_n   = count;
            state_n = S_PULSE;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_PULSE: begin
        rem_n = rem_dec;
        if (rem_dec == '0) begin
          state_n = S_DONE;
        end else if (GAP == 0) begin
          state_n = S_PULSE;
        end else begin
          state_n = S_GAP;
          gap_n   = GAP_INIT;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_n = S_PULSE;
        end else begin
          gap_n = gap_cnt - 4'd1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
`ifdef BC_PG_ABORT_EN
    // The abort overrides the next state only. In PULSE, remaining still
    // takes the decrement because that pulse has already been sent.
    if (abort && ((state == S_PULSE) || (state == S_GAP))) begin
      state_n = S_DONE;
    end
`endif
  end

  always_comb begin
    x    = (state == S_PULSE);
    busy = (state == S_PULSE) || (state == S_GAP);
    done = (state == S_DONE);
  end

endmodule

// File: tb/tb_bc_pulse_gen.sv
// Testbench for bc_pulse_gen. It uses two instances:
//   dut1: WIDTH=2, GAP=1
//   dut0: WIDTH=2, GAP=0
// Each table row drives the inputs for one cycle just after the rising edge.
// The same row pushes the hand-computed outputs expected in that cycle.
// A monitor per instance pops and compares on the falling edge.
module tb_bc_pulse_gen;

  logic       clk;
  logic       reset;
  logic       s1, s0;
  logic [1:0] c1, c0;
`ifdef BC_PG_ABORT_EN
  logic       a1;
`endif
  logic       x1, b1, d1;
  logic [1:0] r1;
  logic       x0, b0, d0;
  logic [1:0] r0;

  typedef struct {
    logic       x;
    logic       b;
    logic       d;
    logic [1:0] r;
    int         tag;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];

  int checks = 0;
  int errors = 0;

  bc_pulse_gen #(.WIDTH(2), .GAP(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .start     (s1),
    .count     (c1),
`ifdef BC_PG_ABORT_EN
    .abort     (a1),
`endif
    .x         (x1),
    .busy      (b1),
    .done      (d1),
    .remaining (r1)
  );

  bc_pulse_gen #(.WIDTH(2), .GAP(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .start     (s0),
    .count     (c0),
`ifdef BC_PG_ABORT_EN
    .abort     (1'b0),
`endif
    .x         (x0),
    .busy      (b0),
    .done      (d0),
    .remaining (r0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      checks++;
      if ({x1, b1, d1, r1} !== {e.x, e.b, e.d, e.r}) begin
        errors++;
        $display("FAIL gap1_row%0d x/busy/done/rem got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 e.tag, x1, b1, d1, r1, e.x, e.b, e.d, e.r);
      end
    end
  end

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      exp_t e;
      e = q0.pop_front();
      checks++;
      if ({x0, b0, d0, r0} !== {e.x, e.b, e.d, e.r}) begin
        errors++;
        $display("FAIL gap0_row%0d x/busy/done/rem got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 e.tag, x0, b0, d0, r0, e.x, e.b, e.d, e.r);
      end
    end
  end

  task automatic push1(input logic ex, input logic eb, input logic ed,
                       input logic [1:0] er, input int tag);
    exp_t e;
    e.x = ex; e.b = eb; e.d = ed; e.r = er; e.tag = tag;
    q1.push_back(e);
  endtask

  task automatic row1(input logic s, input logic [1:0] c,
                      input logic ex, input logic eb, input logic ed,
                      input logic [1:0] er, input int tag);
    @(posedge clk);
    #1;
    s1 = s;
    c1 = c;
    push1(ex, eb, ed, er, tag);
  endtask

  task automatic row0(input logic s, input logic [1:0] c,
                      input logic ex, input logic eb, input logic ed,
                      input logic [1:0] er, input int tag);
    exp_t e;
    @(posedge clk);
    #1;
    s0 = s;
    c0 = c;
    e.x = ex; e.b = eb; e.d = ed; e.r = er; e.tag = tag;
    q0.push_back(e);
  endtask

`ifdef BC_PG_ABORT_EN
  task automatic row1a(input logic s, input logic [1:0] c, input logic a,
                       input logic ex, input logic eb, input logic ed,
                       input logic [1:0] er, input int tag);
    @(posedge clk);
    #1;
    s1 = s;
    c1 = c;
    a1 = a;
    push1(ex, eb, ed, er, tag);
  endtask
`endif

  task automatic check_now(input logic ex, input logic eb, input logic ed,
                           input logic [1:0] er, input int tag);
    checks++;
    if ({x1, b1, d1, r1} !== {ex, eb, ed, er}) begin
      errors++;
      $display("FAIL now_%0d x/busy/done/rem got %b/%b/%b/%0d expected %b/%b/%b/%0d",
               tag, x1, b1, d1, r1, ex, eb, ed, er);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running expected finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    s1 = 1'b0; c1 = '0;
    s0 = 1'b0; c0 = '0;
`ifdef BC_PG_ABORT_EN
    a1 = 1'b0;
`endif
    // Outputs must be zero while reset is held.
    row1(0, 0, 0, 0, 0, 0, 1);
    row0(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1 reset = 1'b1;

    // Basic run: GAP=1, count=3 accepted at edge 0.
    row1(1, 3, 0, 0, 0, 0, 100);
    row1(0, 0, 1, 1, 0, 3, 101);
    row1(0, 0, 0, 1, 0, 2, 102);
    row1(0, 0, 1, 1, 0, 2, 103);
    row1(0, 0, 0, 1, 0, 1, 104);
    row1(0, 0, 1, 1, 0, 1, 105);
    row1(0, 0, 0, 0, 1, 0, 106);
    row1(0, 0, 0, 0, 0, 0, 107);

    // Zero count: done one cycle after acceptance, no pulse.
    row1(1, 0, 0, 0, 0, 0, 200);
    row1(0, 0, 0, 0, 1, 0, 201);
    row1(0, 0, 0, 0, 0, 0, 202);

    // Ignored start: run of 2. Start is held with count=3 through GAP,
    // the last PULSE and DONE, and all of those requests are ignored.
    row1(1, 2, 0, 0, 0, 0, 300);
    row1(0, 0, 1, 1, 0, 2, 301);
    row1(1, 3, 0, 1, 0, 1, 302);
    row1(1, 3, 1, 1, 0, 1, 303);
    row1(1, 3, 0, 0, 1, 0, 304);
    row1(0, 0, 0, 0, 0, 0, 305);
    row1(0, 0, 0, 0, 0, 0, 306);

    // Back-to-back, GAP=0: three adjacent pulses. A start during DONE is
    // ignored. A start in the following IDLE cycle is accepted.
    row0(1, 3, 0, 0, 0, 0, 400);
    row0(0, 0, 1, 1, 0, 3, 401);
    row0(0, 0, 1, 1, 0, 2, 402);
    row0(0, 0, 1, 1, 0, 1, 403);
    row0(1, 1, 0, 0, 1, 0, 404);
    row0(1, 1, 0, 0, 0, 0, 405);
    row0(0, 0, 1, 1, 0, 1, 406);
    row0(0, 0, 0, 0, 1, 0, 407);
    row0(0, 0, 0, 0, 0, 0, 408);

    // Reset mid-run during pulse 2 of 3: asynchronous clear, no done after.
    row1(1, 3, 0, 0, 0, 0, 500);
    row1(0, 0, 1, 1, 0, 3, 501);
    row1(0, 0, 0, 1, 0, 2, 502);
    @(posedge clk);
    #1;
    check_now(1, 1, 0, 2, 503);
    reset = 1'b0;
    #1;
    check_now(0, 0, 0, 0, 504);
    push1(0, 0, 0, 0, 505);
    row1(0, 0, 0, 0, 0, 0, 506);
    @(posedge clk);
    #1;
    reset = 1'b1;
    push1(0, 0, 0, 0, 507);
    row1(0, 0, 0, 0, 0, 0, 508);
    row1(1, 1, 0, 0, 0, 0, 509);
    row1(0, 0, 1, 1, 0, 1, 510);
    row1(0, 0, 0, 0, 1, 0, 511);
    row1(0, 0, 0, 0, 0, 0, 512);

`ifdef BC_PG_ABORT_EN
    // Abort at the edge that ends cycle 2 (GAP). A later abort in IDLE
    // has no effect.
    row1a(1, 3, 0, 0, 0, 0, 0, 600);
    row1a(0, 0, 0, 1, 1, 0, 3, 601);
    row1a(0, 0, 1, 0, 1, 0, 2, 602);
    row1a(0, 0, 0, 0, 0, 1, 2, 603);
    row1a(0, 0, 1, 0, 0, 0, 2, 604);
    row1a(0, 0, 0, 0, 0, 0, 2, 605);
`endif

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ((q1.size() + q0.size()) != 0) begin
      errors++;
      $display("FAIL drain queued got %0d expected 0", q1.size() + q0.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bc_pulse_gen.md
# bc_pulse_gen

Pulse-train transmitter for the 2-bit pulse counter. On a start request it loads a count N and drives exactly N single-cycle pulses on `x`, spaced by a fixed idle gap, then reports completion. Pulses launch on the rising edge of `clk`, so a counter sampling on the falling edge sees `x` stable for half a cycle. The block is used to stimulate and drive the counter in the lab datapath.

## Interface
- `WIDTH`, default 2: width of `count` and `remaining`.
- `GAP`, default 1: idle cycles between consecutive pulses. Legal range 0..15.
- `clk`  in  1: clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset).
- `start`  in  1: request. Sampled only in IDLE.
- `count`  in  WIDTH: number of pulses. Captured on the accepting edge.
- `abort`  in  1: present only with `BC_PG_ABORT_EN`.
- `x`  out  1: pulse output, registered.
- `busy`  out  1: high in PULSE and GAP.
- `done`  out  1: one-cycle completion strobe.
- `remaining`  out  WIDTH: pulses still to send.

## Operation
- Moore FSM with four states: IDLE, PULSE, GAP, DONE. Outputs decode from registered state and counters:
  - `x` = (state == PULSE).
  - `busy` = PULSE or GAP.
  - `done` = DONE.
- IDLE:
  - `start`=1 with `count`≠0: `remaining`←`count`, go to PULSE.
  - `start`=1 with `count`=0: go straight to DONE. No pulse is sent.
  - Otherwise stay in IDLE.
- PULSE, one cycle: `remaining`←`remaining`−1 (WIDTH-bit, never underflows here). Next state:
  - new `remaining`=0: DONE.
  - GAP=0: PULSE.
  - Otherwise: GAP, with gap counter←GAP−1.
- GAP: hold for GAP cycles. A 4-bit gap counter decrements each cycle. At 0, go to PULSE.
- DONE: one cycle, then IDLE.
- `start` outside IDLE is ignored. It is not queued, and `count` is not re-sampled.
- `remaining` holds its last value in IDLE and DONE. This is 0 after a full run.
- Maximum N is 2^WIDTH−1.

## Timing
- Reset asserted: state=IDLE, `x`=0, `busy`=0, `done`=0, `remaining`=0, gap counter=0. Reset takes effect immediately, independent of `clk`.
- Reset mid-run: the run is lost. No `done` is produced. After release the block is in IDLE.
- Start latency: `start` is accepted at edge k. `x` is high from edge k+1 to edge k+2.
- Pulse n (n=0..N−1) is high during cycle k+1+n·(GAP+1).
- Completion: `done` is high for the single cycle after the last pulse, at cycle k+1+N+(N−1)·GAP. IDLE follows on the next edge, so a new `start` is accepted at the earliest 2 cycles after the last pulse.
- `count`=0: `done` is high in cycle k+1. `x` stays 0.

## Configuration
- `BC_PG_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 at an edge while in PULSE or GAP forces DONE on that edge. `x` drops and `done` strobes the next cycle.
  - `remaining` keeps the count of unsent pulses. The pulse in progress has already been counted.
  - `abort` has priority over normal transitions. It has no effect in IDLE or DONE.
- `BC_PG_ABORT_EN` not defined: the `abort` port and all its logic are absent. A run always ends after N pulses or a reset.

## Test plan
- Basic run (WIDTH=2, GAP=1): `start` with `count`=3 at edge 0 -> `x` high in cycles 1, 3, 5; `remaining` 2, 1, 0; `done` in cycle 6; `busy` high in cycles 1–5.
- Zero count: `start` with `count`=0 -> `done` in cycle 1, `x` never high, `busy` never high.
- Back-to-back (GAP=0): `count`=3 -> `x` high in cycles 1–3 continuously, `done` in cycle 4. An attached 2-bit counter ends at 3 with `z`=0.
- Ignored start: run with `count`=2, then pulse `start` with `count`=3 during GAP -> exactly 2 pulses, a single `done`, and `remaining` never reloads.
- Reset mid-run: assert `reset` low asynchronously between edges during pulse 2 of 3 -> all outputs are 0 immediately and no `done` follows. After release, `start` with `count`=1 -> one pulse.
- Abort (macro on): `count`=3, GAP=1, `abort` at the edge ending cycle 2 (GAP) -> `x` is high only in cycle 1, `done` in cycle 3, `remaining`=2.
